// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchroniser, tick-paced per-bit debounce and
// optional registered rise/fall pulses for the slide-switch bank.
// Optional feature macro: SW_DEBOUNCE_EDGE_OUT_EN builds the sw_rise/sw_fall
// pulse registers; when undefined both outputs are tied to 0.
`timescale 1ns/1ps
module sw_debounce_sync #(
   parameter int WIDTH      = 18,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sample_tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_CNT) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   logic [WIDTH-1:0]          sync1_q, sync2_q;
   logic [WIDTH-1:0]          clean_q, clean_d;
   logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]             pre_q, pre_d;
   logic                      tick_q, tick_d;

   // Prescaler wraps at TICK_DIV-1; tick is registered so it is high exactly
   // while the counter holds TICK_DIV-1 and is 0 straight out of reset.
   always_comb begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      tick_d = (pre_d == PRE_LAST);
   end

   // Per-bit debounce: on a tick, a match clears the run, a full run of
   // differing samples accepts the new level, anything else extends the run.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = cnt_q;
      if (tick_q) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               clean_d[i] = sync2_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // State registers: synchroniser, prescaler, counters and accepted levels.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         cnt_q   <= '0;
         clean_q <= '0;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign sw_clean    = clean_q;
   assign sample_tick = tick_q;

`ifdef SW_DEBOUNCE_EDGE_OUT_EN
   logic [WIDTH-1:0] rise_q, fall_q;

   // Pulses land on the same edge as the accepted level they announce.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= clean_d & ~clean_q;
         fall_q <= ~clean_d & clean_q;
      end
   end

   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
`else
   assign sw_rise = '0;
   assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync: directed scenarios plus a randomized run, all
// compared against a window-of-samples reference model.
`timescale 1ns/1ps
module tb_sw_debounce_sync;

   localparam int W       = 18;
   localparam int TD      = 4;
   localparam int SC      = 3;
   localparam int LAT_MIN = 2 + (SC - 1) * TD + 1;
   localparam int LAT_MAX = 2 + SC * TD;
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic [W-1:0]  sw_raw   = '0;
   logic [W-1:0]  sw_clean, sw_rise, sw_fall;
   logic          sample_tick;

   int n_checks = 0;
   int n_fail   = 0;

   sw_debounce_sync #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .sw_clean   (sw_clean),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sample_tick(sample_tick)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: raw is seen two edges late; on each sample instant the
   // sample is appended to a window of the last SC samples, and a bit flips
   // when every sample in a full window disagrees with its accepted level.
   logic [W-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
   logic [W-1:0] m_acc;
   logic [W-1:0] m_hist[$];
   int           cyc = 0;

   always @(posedge CLOCK_50) begin
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
         m_hist.delete();
         cyc = 0;
      end else begin
         m_rise = '0;
         m_fall = '0;
         if ((cyc % TD) == TD - 1) begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > SC) void'(m_hist.pop_front());
            m_acc = '1;
            if (m_hist.size() < SC) m_acc = '0;
            else foreach (m_hist[k]) m_acc &= m_hist[k] ^ m_clean;
            m_rise  = m_acc & ~m_clean;
            m_fall  = m_acc & m_clean;
            m_clean = m_clean ^ m_acc;
         end
         m_s2 = m_s1;
         m_s1 = sw_raw;
         cyc++;
      end
   end

   logic [3*W:0] dut_v, exp_v;
   assign dut_v = {sw_clean, sw_rise, sw_fall, sample_tick};
   assign exp_v = {m_clean, EDGE_EN ? m_rise : {W{1'b0}}, EDGE_EN ? m_fall : {W{1'b0}},
                   ((cyc % TD) == TD - 1)};

   // Stimulus helper: hold reset for n cycles; returns in post-reset cycle 0.
   task automatic do_reset(input logic [W-1:0] raw, input int n);
      @(negedge CLOCK_50);
      reset  = 1'b1;
      sw_raw = raw;
      repeat (n) @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_c, exp_r;
      logic         exp_t;
      @(negedge CLOCK_50);
      reset  = 1'b1;
      sw_raw = '1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=0", k, dut_v);
         end
      end
      reset = 1'b0;
      for (int k = 0; k <= SC * TD + 2; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         exp_c = (k >= SC * TD) ? '1 : '0;
         exp_r = (EDGE_EN && k == SC * TD) ? '1 : '0;
         exp_t = ((k % TD) == TD - 1);
         n_checks++;
         if (dut_v !== {exp_c, exp_r, {W{1'b0}}, exp_t}) begin
            n_fail++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, dut_v,
                     {exp_c, exp_r, {W{1'b0}}, exp_t});
         end
      end
   endtask

   task automatic test_clean_step();
      int lat = 0;
      bit seen = 0;
      do_reset('0, 2);
      repeat ($urandom_range(0, 7)) @(negedge CLOCK_50);
      sw_raw[17] = 1'b1;
      for (int k = 1; k <= LAT_MAX + 4; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL step_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
         end
         if (!seen && sw_clean[17] === 1'b1) begin
            seen = 1;
            lat  = k;
            n_checks++;
            if (sw_rise !== (EDGE_EN ? 18'h20000 : 18'h0) || sw_fall !== '0) begin
               n_fail++;
               $display("FAIL step_pulse got rise=%h fall=%h exp rise=%h fall=0",
                        sw_rise, sw_fall, EDGE_EN ? 18'h20000 : 18'h0);
            end
         end
      end
      n_checks++;
      if (!seen || lat < LAT_MIN || lat > LAT_MAX) begin
         n_fail++;
         $display("FAIL step_latency got=%0d (seen=%0d) exp=%0d..%0d", lat, seen, LAT_MIN, LAT_MAX);
      end
   endtask

   task automatic test_bounce();
      int lat = 0;
      bit seen = 0;
      do_reset('0, 2);
      repeat ($urandom_range(0, 7)) @(negedge CLOCK_50);
      for (int seg = 0; seg < 3; seg++) begin
         sw_raw[3] = (seg != 1);
         for (int k = 1; k <= 5; k++) begin
            @(negedge CLOCK_50);
            n_checks++;
            if (dut_v !== exp_v) begin
               n_fail++;
               $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            end
            n_checks++;
            if (sw_clean[3] !== 1'b0 || sw_rise[3] !== 1'b0) begin
               n_fail++;
               $display("FAIL bounce_hold seg=%0d got clean=%b rise=%b exp 0", seg,
                        sw_clean[3], sw_rise[3]);
            end
         end
      end
      for (int k = 6; k <= LAT_MAX + 4; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
         end
         if (!seen && sw_clean[3] === 1'b1) begin
            seen = 1;
            lat  = k;
         end
      end
      n_checks++;
      if (!seen || lat < LAT_MIN || lat > LAT_MAX) begin
         n_fail++;
         $display("FAIL bounce_latency got=%0d (seen=%0d) exp=%0d..%0d", lat, seen, LAT_MIN, LAT_MAX);
      end
   endtask

   task automatic test_simultaneous();
      bit seen = 0;
      do_reset('0, 2);
      repeat ($urandom_range(0, 7)) @(negedge CLOCK_50);
      sw_raw = {2'b00, 8'hA5, 8'h5A};
      for (int k = 1; k <= LAT_MAX + 4; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL simul_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
         end
         if (!seen && sw_clean !== '0) begin
            seen = 1;
            n_checks++;
            if (sw_clean !== 18'h0A55A || sw_rise !== (EDGE_EN ? 18'h0A55A : 18'h0)) begin
               n_fail++;
               $display("FAIL simul_edge got clean=%h rise=%h exp clean=0a55a rise=%h",
                        sw_clean, sw_rise, EDGE_EN ? 18'h0A55A : 18'h0);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL simul_timeout got clean=%h exp=0a55a", sw_clean);
      end
   endtask

   task automatic test_reset_mid();
      do_reset('0, 2);
      sw_raw[0] = 1'b1;
      // Two ticks accumulate (cycles TD-1 and 2TD-1), then reset hits.
      for (int k = 1; k <= 2 * TD; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (sw_clean !== '0 || sw_rise !== '0 || sw_fall !== '0) begin
            n_fail++;
            $display("FAIL mid_pre cyc=%0d got clean=%h rise=%h exp 0", k, sw_clean, sw_rise);
         end
      end
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=0", dut_v);
         end
      end
      reset = 1'b0;
      for (int k = 0; k <= SC * TD + 2; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         n_checks++;
         if (sw_clean[0] !== (k >= SC * TD) ||
             sw_rise[0] !== (EDGE_EN && k == SC * TD)) begin
            n_fail++;
            $display("FAIL mid_reaccept cyc=%0d got clean=%b rise=%b exp clean=%b rise=%b", k,
                     sw_clean[0], sw_rise[0], k >= SC * TD, EDGE_EN && k == SC * TD);
         end
         n_checks++;
         if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_random();
      do_reset('0, 2);
      for (int n = 0; n < 600; n++) begin
         @(negedge CLOCK_50);
         n_checks++;
         if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL rand_model n=%0d cyc=%0d got=%h exp=%h", n, cyc, dut_v, exp_v);
         end
         reset = ($urandom_range(0, 249) == 0);
         // Low bits chatter (bounces), high bits change rarely (clean steps).
         for (int b = 0; b < W; b++) begin
            if (b < 4) begin
               if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
            end else begin
               if ($urandom_range(0, 59) == 0) sw_raw[b] = ~sw_raw[b];
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
